timer_array: RTL and testbench
==============================

# timer_array

Parametrised multi-channel timer block: the successor to the single-channel 32-bit timer peripheral in the RISC-V microcontroller. It provides `NCH` independent channels of width `W`, each with one-shot or continuous mode. Each channel drives a registered terminal-count pulse and a sticky interrupt flag, and the flags combine into one masked `irq` line toward the interrupt controller. The block sits behind the peripheral register file, which drives its trigger/config inputs and reads back its status.

## Interface
- `NCH`, 4: number of channels (1..16)
- `W`, 32: counter/terminal-count width (8..32)
- `PW`, 16: prescaler width
- `clk` in 1: master clock
- `reset` in 1: asynchronous, active-low reset
- `trig_start` in NCH: per-channel start strobe (one-cycle)
- `trig_halt` in NCH: per-channel halt strobe (one-cycle)
- `mode` in NCH: 1 = continuous, 0 = one-shot
- `termcount` in NCH*W: per-channel terminal count; channel i occupies bits [i*W +: W]
- `int_en` in NCH: per-channel interrupt mask
- `int_clr` in NCH: per-channel sticky-flag clear strobe
- `prescale` in PW: tick divider; tick period is prescale+1 clocks
- `status` out NCH: channel running
- `currcount` out NCH*W: per-channel current count
- `int_pulse` out NCH: one-cycle terminal-count pulse
- `int_flag` out NCH: sticky terminal-count flag
- `irq` out 1: OR over (int_flag & int_en), registered

## Operation
- Reset values: all outputs 0. Prescaler counter is 0.
- Each channel is a two-state FSM:
  - IDLE (status=0) goes to RUN on `trig_start`. `currcount` loads 0.
  - RUN goes to IDLE on `trig_halt`, or on one-shot terminal.
- `trig_start` while in RUN is ignored; the count is not restarted.
- `trig_halt` in any state: status←0, currcount←0. If start and halt arrive in the same cycle, halt wins.
- Counting happens only in RUN, and only on a tick cycle:
  - If currcount != termcount: currcount←currcount+1, modulo 2^W.
  - If currcount == termcount in continuous mode: currcount←0, int_pulse←1. The period is termcount+1 ticks.
  - If currcount == termcount in one-shot mode: int_pulse←1, status←0, and currcount holds at termcount until the next start.
- termcount=0:
  - Continuous mode pulses on every tick.
  - One-shot mode pulses on the first tick after start.
- If termcount is lowered below currcount while running, the counter continues, wraps through 2^W-1→0, and then matches. Mode and termcount are sampled live every cycle.
- int_flag[i] is set on int_pulse[i] and cleared by int_clr[i]. If set and clear occur in the same cycle, set wins.
- `irq` is the registered OR of int_flag & int_en.
- Channels are fully independent except for the shared tick.

## Timing
- Start is sampled at edge t. At edge t, status=1 and currcount=0. The first tick at or after edge t+1 increments the count.
- int_pulse is registered: it is high for exactly one clock, in the same cycle the count returns to 0 (continuous) or status drops (one-shot).
- int_flag rises together with int_pulse. `irq` follows int_flag one cycle later.
- Halt takes effect at the sampling edge. An int_pulse already high completes its single cycle.
- Asserting `reset` mid-count clears everything immediately. Counting resumes only after a new start.

## Configuration
- `TIMER_PRESCALE_EN` defined:
  - A shared PW-bit prescaler counts 0..prescale and asserts tick when it equals prescale, then reloads 0.
  - prescale=0 gives a tick every clock.
  - If prescale is changed below the current prescaler value, the prescaler wraps at 2^PW.
- `TIMER_PRESCALE_EN` undefined:
  - tick is constant 1 and there is no prescaler register.
  - The `prescale` port remains present but is ignored.

## Structure
- Package `timer_pkg`:
  - mode encoding constants (MODE_ONESHOT=0, MODE_CONT=1)
  - channel state enum (IDLE, RUN)
  - default parameter values
- Sub-module `timer_channel`, instantiated NCH times via generate. It holds one FSM, counter, int_pulse and int_flag.
- The top level holds the prescaler, the irq reduction and the slicing of the packed vectors.

## Test plan
- Continuous mode: ch0 mode=1, termcount=3, prescale=0, start → int_pulse every 4 clocks, and currcount sequence 0,1,2,3,0.
- One-shot mode: ch1 mode=0, termcount=5, start → a single int_pulse 6 clocks after start. status drops in the same cycle, and currcount holds at 5. A second start reloads 0.
- Simultaneous events:
  - start and halt in the same cycle → status stays 0 and currcount stays 0.
  - int_pulse and int_clr in the same cycle → int_flag=1.
- Prescaler (TIMER_PRESCALE_EN): prescale=2, termcount=1, continuous → int_pulse every 6 clocks. Without the macro → every 2 clocks.
- Interrupt masking: flags set on ch0 and ch2, int_en=4'b0100 → irq=1. int_clr[2] → irq=0 one cycle after the flag clears.
- Reset and wrap:
  - reset asserted mid-count (currcount=7) → all outputs 0 asynchronously.
  - W=8, termcount lowered to 2 while currcount=10 → count wraps 255→0, then pulses at 2.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared constants, channel state type and default sizing for timer_array.
package timer_pkg;

  localparam int DEF_NCH = 4;
  localparam int DEF_W   = 32;
  localparam int DEF_PW  = 16;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } chan_state_e;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: IDLE/RUN state machine, W-bit counter, registered
// terminal-count pulse and sticky interrupt flag.
module timer_channel
  import timer_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_tick,
  input  logic         i_start,
  input  logic         i_halt,
  input  logic         i_mode,
  input  logic [W-1:0] i_termcount,
  input  logic         i_clr,
  output logic         o_status,
  output logic [W-1:0] o_count,
  output logic         o_pulse,
  output logic         o_flag
);

  chan_state_e  r_state;
  logic [W-1:0] r_count;
  logic         r_pulse;
  logic         r_flag;

  // Channel state machine, counter, terminal pulse and sticky flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_count <= {W{1'b0}};
      r_pulse <= 1'b0;
      r_flag  <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      // A terminal hit below overrides this clear, so set wins.
      r_flag  <= r_flag & ~i_clr;
      if (i_halt) begin
        r_state <= ST_IDLE;
        r_count <= {W{1'b0}};
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (i_start) begin
              r_state <= ST_RUN;
              r_count <= {W{1'b0}};
            end else begin
              r_state <= ST_IDLE;
            end
          end
          ST_RUN: begin
            if (!i_tick) begin
              r_state <= ST_RUN;
            end else if (r_count != i_termcount) begin
              r_count <= r_count + W'(1);
            end else begin
              r_pulse <= 1'b1;
              r_flag  <= 1'b1;
              if (i_mode == MODE_CONT) begin
                r_count <= {W{1'b0}};
              end else begin
                // One-shot keeps the terminal value visible until the next start.
                r_state <= ST_IDLE;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_count <= {W{1'b0}};
          end
        endcase
      end
    end
  end

  assign o_status = (r_state == ST_RUN);
  assign o_count  = r_count;
  assign o_pulse  = r_pulse;
  assign o_flag   = r_flag;

endmodule

// File: rtl/timer_array.sv
// NCH-channel timer with shared tick and masked, registered irq.
// Define TIMER_PRESCALE_EN to divide the tick by prescale+1; otherwise every clock ticks.
module timer_array
  import timer_pkg::*;
#(
  parameter int NCH = DEF_NCH,
  parameter int W   = DEF_W,
  parameter int PW  = DEF_PW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   trig_start,
  input  logic [NCH-1:0]   trig_halt,
  input  logic [NCH-1:0]   mode,
  input  logic [NCH*W-1:0] termcount,
  input  logic [NCH-1:0]   int_en,
  input  logic [NCH-1:0]   int_clr,
  input  logic [PW-1:0]    prescale,
  output logic [NCH-1:0]   status,
  output logic [NCH*W-1:0] currcount,
  output logic [NCH-1:0]   int_pulse,
  output logic [NCH-1:0]   int_flag,
  output logic             irq
);

  logic           w_tick;
  logic [NCH-1:0] w_flag;
  logic           r_irq;

`ifdef TIMER_PRESCALE_EN
  logic [PW-1:0] r_presc;

  assign w_tick = (r_presc == prescale);

  // Free-running prescaler; a lowered limit wraps through 2^PW before matching
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_presc <= {PW{1'b0}};
    end else if (w_tick) begin
      r_presc <= {PW{1'b0}};
    end else begin
      r_presc <= r_presc + PW'(1);
    end
  end
`else
  logic w_unused_prescale;

  assign w_tick            = 1'b1;
  assign w_unused_prescale = ^prescale;
`endif

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    timer_channel #(.W(W)) u_ch (
      .clk         (clk),
      .reset       (reset),
      .i_tick      (w_tick),
      .i_start     (trig_start[g]),
      .i_halt      (trig_halt[g]),
      .i_mode      (mode[g]),
      .i_termcount (termcount[g*W +: W]),
      .i_clr       (int_clr[g]),
      .o_status    (status[g]),
      .o_count     (currcount[g*W +: W]),
      .o_pulse     (int_pulse[g]),
      .o_flag      (w_flag[g])
    );
  end

  // Masked interrupt reduction, one cycle behind the flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(w_flag & int_en);
    end
  end

  assign int_flag = w_flag;
  assign irq      = r_irq;

endmodule

// File: tb/tb_timer_array.sv
// Directed bench for timer_array: expected pulses go into a scoreboard queue,
// a negedge monitor matches them against int_pulse.
module tb_timer_array;

  localparam int NCH = 4;
  localparam int W   = 8;
  localparam int PW  = 16;

  logic             clk;
  logic             reset;
  logic [NCH-1:0]   trig_start;
  logic [NCH-1:0]   trig_halt;
  logic [NCH-1:0]   mode;
  logic [NCH*W-1:0] termcount;
  logic [NCH-1:0]   int_en;
  logic [NCH-1:0]   int_clr;
  logic [PW-1:0]    prescale;
  logic [NCH-1:0]   status;
  logic [NCH*W-1:0] currcount;
  logic [NCH-1:0]   int_pulse;
  logic [NCH-1:0]   int_flag;
  logic             irq;

  timer_array #(.NCH(NCH), .W(W), .PW(PW)) dut (
    .clk        (clk),
    .reset      (reset),
    .trig_start (trig_start),
    .trig_halt  (trig_halt),
    .mode       (mode),
    .termcount  (termcount),
    .int_en     (int_en),
    .int_clr    (int_clr),
    .prescale   (prescale),
    .status     (status),
    .currcount  (currcount),
    .int_pulse  (int_pulse),
    .int_flag   (int_flag),
    .irq        (irq)
  );

  typedef struct {
    int         ch;
    int         cyc;
    logic [7:0] cnt;
    logic       st;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic set_tc(input int ch, input logic [7:0] v);
    termcount[ch*W +: W] = v;
  endtask

  function automatic logic [7:0] cnt(input int ch);
    return currcount[ch*W +: W];
  endfunction

  task automatic expect_pulse(input int ch, input int at, input logic [7:0] c, input logic st);
    exp_t e;
    e.ch = ch; e.cyc = at; e.cnt = c; e.st = st;
    q.push_back(e);
  endtask

  // Scoreboard monitor: every observed pulse must match the oldest expectation for its channel
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) begin
        if (int_pulse[i]) begin
          int idx;
          idx = -1;
          foreach (q[j]) if (idx < 0 && q[j].ch == i) idx = j;
          checks++;
          if (idx < 0) begin
            errors++;
            $display("FAIL pulse_unexpected ch%0d: got pulse at cycle %0d expected none", i, cyc);
          end else begin
            if (q[idx].cyc != cyc || q[idx].cnt !== cnt(i) || q[idx].st !== status[i]
                || int_flag[i] !== 1'b1) begin
              errors++;
              $display("FAIL pulse_ch%0d: got cyc=%0d cnt=%0d st=%0b flag=%0b expected cyc=%0d cnt=%0d st=%0b flag=1",
                       i, cyc, cnt(i), status[i], int_flag[i], q[idx].cyc, q[idx].cnt, q[idx].st);
            end
            q.delete(idx);
          end
        end
      end
    end
  end

  initial begin
    int t;
    int first;
    int per;
    logic [7:0] seq [5];
    seq[0] = 8'd0; seq[1] = 8'd1; seq[2] = 8'd2; seq[3] = 8'd3; seq[4] = 8'd0;

    trig_start = '0; trig_halt = '0; mode = '0; termcount = '0;
    int_en = '0; int_clr = '0; prescale = '0;
    reset = 1'b1;
    #3 reset = 1'b0;
    step(2);
    chk("rst_status", 32'(status), 32'd0);
    chk("rst_count", currcount, 32'd0);
    chk("rst_pulse", 32'(int_pulse), 32'd0);
    chk("rst_flag", 32'(int_flag), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    reset = 1'b1;
    step(2);

    // Continuous: ch0, termcount 3
    mode[0] = 1'b1; set_tc(0, 8'd3); trig_start[0] = 1'b1; t = cyc + 1;
    expect_pulse(0, t + 4, 8'd0, 1'b1);
    expect_pulse(0, t + 8, 8'd0, 1'b1);
    expect_pulse(0, t + 12, 8'd0, 1'b1);
    step(1); trig_start[0] = 1'b0;
    chk("cont_status", 32'(status[0]), 32'd1);
    chk("cont_seq0", 32'(cnt(0)), 32'(seq[0]));
    for (int k = 1; k < 5; k++) begin
      step(1);
      chk("cont_seq", 32'(cnt(0)), 32'(seq[k]));
    end
    step(8);
    trig_halt[0] = 1'b1; step(1); trig_halt[0] = 1'b0;
    chk("halt_status", 32'(status[0]), 32'd0);
    chk("halt_count", 32'(cnt(0)), 32'd0);
    chk("cont_flag_masked_irq", 32'(irq), 32'd0);

    // One-shot: ch1, termcount 5
    mode[1] = 1'b0; set_tc(1, 8'd5); trig_start[1] = 1'b1; t = cyc + 1;
    expect_pulse(1, t + 6, 8'd5, 1'b0);
    step(1); trig_start[1] = 1'b0;
    chk("os_status_run", 32'(status[1]), 32'd1);
    step(6);
    chk("os_status_done", 32'(status[1]), 32'd0);
    chk("os_count_hold", 32'(cnt(1)), 32'd5);
    step(3);
    chk("os_count_hold_later", 32'(cnt(1)), 32'd5);
    trig_start[1] = 1'b1; step(1); trig_start[1] = 1'b0;
    chk("os_restart_count", 32'(cnt(1)), 32'd0);
    chk("os_restart_status", 32'(status[1]), 32'd1);
    trig_halt[1] = 1'b1; step(1); trig_halt[1] = 1'b0;
    chk("os_halt_status", 32'(status[1]), 32'd0);

    // Start and halt together: halt wins
    mode[3] = 1'b1; set_tc(3, 8'd2);
    trig_start[3] = 1'b1; trig_halt[3] = 1'b1; step(1);
    trig_start[3] = 1'b0; trig_halt[3] = 1'b0;
    chk("sh_status", 32'(status[3]), 32'd0);
    chk("sh_count", 32'(cnt(3)), 32'd0);
    step(3);
    chk("sh_status_later", 32'(status[3]), 32'd0);

    // Pulse and clear together: set wins
    mode[2] = 1'b1; set_tc(2, 8'd1); trig_start[2] = 1'b1; t = cyc + 1;
    expect_pulse(2, t + 2, 8'd0, 1'b1);
    step(1); trig_start[2] = 1'b0;
    step(1); int_clr[2] = 1'b1;
    step(1); int_clr[2] = 1'b0;
    chk("setclr_flag", 32'(int_flag[2]), 32'd1);
    trig_halt[2] = 1'b1; step(1); trig_halt[2] = 1'b0;
    chk("setclr_flag_sticky", 32'(int_flag[2]), 32'd1);

    // Interrupt masking
    int_clr = 4'b0010; step(1); int_clr = 4'b0000;
    chk("mask_flags", 32'(int_flag), 32'h5);
    int_en = 4'b0100; step(1);
    chk("mask_irq_on", 32'(irq), 32'd1);
    int_clr[2] = 1'b1; step(1); int_clr[2] = 1'b0;
    chk("mask_flag2_clr", 32'(int_flag[2]), 32'd0);
    chk("mask_irq_lag", 32'(irq), 32'd1);
    step(1);
    chk("mask_irq_off", 32'(irq), 32'd0);
    int_en = 4'b0001; step(1);
    chk("mask_irq_ch0", 32'(irq), 32'd1);
    int_en = 4'b0000; int_clr = 4'b1111; step(1); int_clr = 4'b0000;
    chk("mask_clear_all", 32'(int_flag), 32'd0);

    // Prescaler period: ch0, termcount 1
`ifdef TIMER_PRESCALE_EN
    per = 6;
`else
    per = 2;
`endif
    mode[0] = 1'b1; set_tc(0, 8'd1); prescale = 16'd2; trig_start[0] = 1'b1; t = cyc + 1;
`ifdef TIMER_PRESCALE_EN
    first = t + 5;
`else
    first = t + 2;
`endif
    expect_pulse(0, first, 8'd0, 1'b1);
    expect_pulse(0, first + per, 8'd0, 1'b1);
    step(1); trig_start[0] = 1'b0;
    step(first + per - t);
    prescale = 16'd0; trig_halt[0] = 1'b1; step(1); trig_halt[0] = 1'b0;
    chk("presc_halt", 32'(status[0]), 32'd0);

    // Lowered termcount wraps through 255
    mode[3] = 1'b1; set_tc(3, 8'd20); trig_start[3] = 1'b1; t = cyc + 1;
    step(1); trig_start[3] = 1'b0;
    step(10);
    chk("wrap_at10", 32'(cnt(3)), 32'd10);
    set_tc(3, 8'd2);
    expect_pulse(3, t + 259, 8'd0, 1'b1);
    step(245);
    chk("wrap_at255", 32'(cnt(3)), 32'd255);
    step(1);
    chk("wrap_to0", 32'(cnt(3)), 32'd0);
    chk("wrap_run", 32'(status[3]), 32'd1);
    step(3);
    trig_halt[3] = 1'b1; step(1); trig_halt[3] = 1'b0;
    int_clr = 4'b1111; step(1); int_clr = 4'b0000;

    // Asynchronous reset mid-count
    mode[0] = 1'b1; set_tc(0, 8'd20); mode[1] = 1'b0; set_tc(1, 8'd0);
    int_en = 4'b0010; trig_start = 4'b0011; t = cyc + 1;
    expect_pulse(1, t + 1, 8'd0, 1'b0);
    step(1); trig_start = 4'b0000;
    step(7);
    chk("pre_rst_count", 32'(cnt(0)), 32'd7);
    chk("pre_rst_irq", 32'(irq), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_status", 32'(status), 32'd0);
    chk("arst_count", currcount, 32'd0);
    chk("arst_flag", 32'(int_flag), 32'd0);
    chk("arst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(3);
    chk("post_rst_idle", 32'(status), 32'd0);
    chk("post_rst_count", 32'(cnt(0)), 32'd0);

    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
